// File: rtl/uart_pkg.sv
// Shared UART types and constants.
// Used by the receiver, transmitter and baud generator.
package uart_pkg;

   localparam int UART_OVERSAMPLE = 16;

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      PARITY,
      STOP
   } rx_state_t;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for asynchronous inputs.
// The reset value is set per use so idle-high lines do not glitch.
module sync_2ff #(
   parameter int                 WIDTH   = 1,
   parameter logic [WIDTH-1:0]   RST_VAL = '1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q
);

   logic [WIDTH-1:0] meta;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         meta <= RST_VAL;
         q    <= RST_VAL;
      end else begin
         meta <= d;
         q    <= meta;
      end
   end

endmodule

// File: rtl/uart_rx.sv
// UART receive deserializer: oversampled start/data/parity/stop recovery.
// Emits one rx_done_tick per frame with dout and error flags held until the next.
module uart_rx
   import uart_pkg::*;
#(
   parameter int DATA_BITS  = 8,
   parameter int OVERSAMPLE = UART_OVERSAMPLE,
   parameter int PARITY_EN  = 0,
   parameter int PARITY_ODD = 0
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 rx,
   input  logic                 s_tick,
   output logic [DATA_BITS-1:0] dout,
   output logic                 rx_done_tick,
   output logic                 frame_err,
   output logic                 parity_err
);

   localparam int SW = $clog2(OVERSAMPLE);
   localparam int NW = $clog2(DATA_BITS);

   localparam logic [SW-1:0] S_MID  = SW'(OVERSAMPLE / 2 - 1);
   localparam logic [SW-1:0] S_END  = SW'(OVERSAMPLE - 1);
   localparam logic [NW-1:0] N_LAST = NW'(DATA_BITS - 1);
   localparam logic          ODD    = (PARITY_ODD != 0);
   localparam logic          HAS_P  = (PARITY_EN != 0);

   rx_state_t            state;
   logic                 rx_s;
   logic [SW-1:0]        s_cnt;
   logic [NW-1:0]        n_cnt;
   logic [DATA_BITS-1:0] b_reg;
   logic                 par_bad;
   logic                 armed;

   sync_2ff #(
      .WIDTH   (1),
      .RST_VAL (1'b1)
   ) u_rx_sync (
      .clk   (clk),
      .rst_n (rst_n),
      .d     (rx),
      .q     (rx_s)
   );

   // armed blocks a line held low through reset from looking like a start edge
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state        <= IDLE;
         s_cnt        <= '0;
         n_cnt        <= '0;
         b_reg        <= '0;
         par_bad      <= 1'b0;
         armed        <= 1'b0;
         dout         <= '0;
         rx_done_tick <= 1'b0;
         frame_err    <= 1'b0;
         parity_err   <= 1'b0;
      end else begin
         rx_done_tick <= 1'b0;
         if (rx_s) armed <= 1'b1;
         unique case (state)
            IDLE: begin
               if (armed && !rx_s) begin
                  state <= START;
                  s_cnt <= '0;
               end
            end
            START: begin
               if (s_tick) begin
                  if (s_cnt == S_MID) begin
                     s_cnt <= '0;
                     n_cnt <= '0;
                     state <= rx_s ? IDLE : DATA;
                  end else begin
                     s_cnt <= s_cnt + 1'b1;
                  end
               end
            end
            DATA: begin
               if (s_tick) begin
                  if (s_cnt == S_END) begin
                     s_cnt <= '0;
                     b_reg <= {rx_s, b_reg[DATA_BITS-1:1]};
                     if (n_cnt == N_LAST) begin
                        state <= HAS_P ? PARITY : STOP;
                     end else begin
                        n_cnt <= n_cnt + 1'b1;
                     end
                  end else begin
                     s_cnt <= s_cnt + 1'b1;
                  end
               end
            end
            PARITY: begin
               if (s_tick) begin
                  if (s_cnt == S_END) begin
                     s_cnt   <= '0;
                     par_bad <= ((^b_reg) ^ rx_s) != ODD;
                     state   <= STOP;
                  end else begin
                     s_cnt <= s_cnt + 1'b1;
                  end
               end
            end
            STOP: begin
               if (s_tick) begin
                  if (s_cnt == S_END) begin
                     s_cnt        <= '0;
                     dout         <= b_reg;
                     frame_err    <= ~rx_s;
                     parity_err   <= HAS_P & par_bad;
                     rx_done_tick <= 1'b1;
                     state        <= IDLE;
                  end else begin
                     s_cnt <= s_cnt + 1'b1;
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: 8N1 instance plus an 8E1 instance.
// Line is driven at 16 clocks per bit with s_tick held high.
module tb_uart_rx;
   import uart_pkg::*;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       rx;
   logic       rx_p;
   logic       s_tick;
   logic [7:0] dout;
   logic       done;
   logic       ferr;
   logic       perr;
   logic [7:0] dout_p;
   logic       done_p;
   logic       ferr_p;
   logic       perr_p;

   int         checks = 0;
   int         fails  = 0;
   int         cyc    = 0;
   int         t_start = 0;
   int         t_done = 0;
   int         n_done = 0;
   int         n_done_p = 0;
   int         long_pulses = 0;
   logic       prev_done = 1'b0;
   logic [7:0] q[$];

   uart_rx dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .rx           (rx),
      .s_tick       (s_tick),
      .dout         (dout),
      .rx_done_tick (done),
      .frame_err    (ferr),
      .parity_err   (perr)
   );

   uart_rx #(
      .PARITY_EN  (1),
      .PARITY_ODD (0)
   ) dut_p (
      .clk          (clk),
      .rst_n        (rst_n),
      .rx           (rx_p),
      .s_tick       (s_tick),
      .dout         (dout_p),
      .rx_done_tick (done_p),
      .frame_err    (ferr_p),
      .parity_err   (perr_p)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      prev_done <= done;
      if (done && prev_done) long_pulses <= long_pulses + 1;
      if (done) begin
         n_done <= n_done + 1;
         t_done <= cyc;
         q.push_back(dout);
      end
      if (done_p) n_done_p <= n_done_p + 1;
   end

   task automatic check(input string tag, input logic [31:0] got,
                        input logic [31:0] exp);
      checks++;
      assert (got === exp) else begin
         fails++;
         $error("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic put(input logic v, input logic on_p);
      if (on_p) rx_p = v;
      else rx = v;
      repeat (16) @(negedge clk);
   endtask

   task automatic send(input logic [7:0] d, input logic par_en,
                       input logic pbit, input logic stopb,
                       input logic on_p);
      t_start = cyc;
      put(1'b0, on_p);
      for (int i = 0; i < 8; i++) put(d[i], on_p);
      if (par_en) put(pbit, on_p);
      put(stopb, on_p);
      if (on_p) rx_p = 1'b1;
      else rx = 1'b1;
   endtask

   initial begin
      int base;
      rst_n  = 1'b0;
      rx     = 1'b1;
      rx_p   = 1'b1;
      s_tick = 1'b1;
      repeat (3) @(negedge clk);
      check("rst_dout", 32'(dout), 32'h00);
      check("rst_done", 32'(done), 32'h0);
      check("rst_ferr", 32'(ferr), 32'h0);
      check("rst_perr", 32'(perr), 32'h0);
      rst_n = 1'b1;
      repeat (5) @(negedge clk);

      // 2 sync + 1 detect + 152 ticks = 155 clocks from line edge
      send(8'hA5, 1'b0, 1'b0, 1'b1, 1'b0);
      repeat (4) @(negedge clk);
      check("a5_count", 32'(n_done), 32'd1);
      check("a5_dout", 32'(dout), 32'hA5);
      check("a5_ferr", 32'(ferr), 32'h0);
      check("a5_perr", 32'(perr), 32'h0);
      check("a5_latency", 32'(t_done - t_start), 32'd155);

      rx = 1'b0;
      repeat (3) @(negedge clk);
      rx = 1'b1;
      repeat (40) @(negedge clk);
      check("glitch_count", 32'(n_done), 32'd1);
      check("glitch_state", 32'(dut.state), 32'(IDLE));
      check("glitch_dout", 32'(dout), 32'hA5);

      send(8'h3C, 1'b0, 1'b0, 1'b0, 1'b0);
      repeat (30) @(negedge clk);
      check("ferr_count", 32'(n_done), 32'd2);
      check("ferr_dout", 32'(dout), 32'h3C);
      check("ferr_set", 32'(ferr), 32'h1);
      send(8'h55, 1'b0, 1'b0, 1'b1, 1'b0);
      repeat (4) @(negedge clk);
      check("ferr_next_count", 32'(n_done), 32'd3);
      check("ferr_next_dout", 32'(dout), 32'h55);
      check("ferr_clear", 32'(ferr), 32'h0);

      send(8'h07, 1'b1, 1'b1, 1'b1, 1'b1);
      repeat (4) @(negedge clk);
      check("par_ok_count", 32'(n_done_p), 32'd1);
      check("par_ok_dout", 32'(dout_p), 32'h07);
      check("par_ok_perr", 32'(perr_p), 32'h0);
      check("par_ok_ferr", 32'(ferr_p), 32'h0);
      send(8'h07, 1'b1, 1'b0, 1'b1, 1'b1);
      repeat (4) @(negedge clk);
      check("par_bad_count", 32'(n_done_p), 32'd2);
      check("par_bad_perr", 32'(perr_p), 32'h1);
      check("par_main_idle", 32'(n_done), 32'd3);

      base = q.size();
      send(8'h00, 1'b0, 1'b0, 1'b1, 1'b0);
      send(8'hFF, 1'b0, 1'b0, 1'b1, 1'b0);
      send(8'h81, 1'b0, 1'b0, 1'b1, 1'b0);
      repeat (4) @(negedge clk);
      check("b2b_count", 32'(n_done), 32'd6);
      check("b2b_0", 32'(q[base]), 32'h00);
      check("b2b_1", 32'(q[base+1]), 32'hFF);
      check("b2b_2", 32'(q[base+2]), 32'h81);
      check("b2b_ferr", 32'(ferr), 32'h0);
      check("b2b_perr", 32'(perr), 32'h0);

      put(1'b0, 1'b0);
      for (int i = 0; i < 4; i++) put(1'b0, 1'b0);
      rx = 1'b1;
      repeat (8) @(negedge clk);
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      check("mid_rst_dout", 32'(dout), 32'h00);
      check("mid_rst_done", 32'(done), 32'h0);
      check("mid_rst_state", 32'(dut.state), 32'(IDLE));
      check("mid_rst_perr_p", 32'(perr_p), 32'h0);
      rst_n = 1'b1;
      repeat (40) @(negedge clk);
      check("mid_rst_nopulse", 32'(n_done), 32'd6);
      send(8'h12, 1'b0, 1'b0, 1'b1, 1'b0);
      repeat (4) @(negedge clk);
      check("after_rst_count", 32'(n_done), 32'd7);
      check("after_rst_dout", 32'(dout), 32'h12);
      check("after_rst_ferr", 32'(ferr), 32'h0);
      check("pulse_width", 32'(long_pulses), 32'd0);

      $display("%0d/%0d checks passed", checks - fails, checks);
      $finish;
   end

endmodule

// File: doc/uart_rx.md
# uart_rx

UART receive deserializer for the SoC UART.
- Oversamples the asynchronous `rx` line using a baud tick from the shared baud generator.
- Recovers start, data, optional parity and stop bits.
- Presents each received word with a one-cycle `rx_done_tick`.
- Sits directly upstream of the receive flag buffer: `rx_done_tick` drives its `flag_set`, `dout` drives its `din`.

## Interface
Parameters:
- `DATA_BITS`, 8, data bits per frame (5–8 legal).
- `OVERSAMPLE`, 16, `s_tick` pulses per bit period (even, ≥8).
- `PARITY_EN`, 0, 1 = one parity bit follows data.
- `PARITY_ODD`, 0, 1 = odd parity, 0 = even; ignored when `PARITY_EN=0`.

Ports:
- `clk`  in  1  system clock.
- `rst_n`  in  1  reset; asynchronous, active-low.
- `rx`  in  1  serial line, asynchronous to `clk`, idle high.
- `s_tick`  in  1  single-cycle enable, `OVERSAMPLE` pulses per bit.
- `dout`  out  `DATA_BITS`  last received word, LSB first on line.
- `rx_done_tick`  out  1  one-cycle pulse, frame complete.
- `frame_err`  out  1  stop bit sampled low on last frame.
- `parity_err`  out  1  parity mismatch on last frame; always 0 when `PARITY_EN=0`.

Clocking: one clock; reset is asynchronous and active-low.

## Operation
- `rx` passes through a 2-flop synchronizer; both flops reset to 1. All logic below uses the synchronized value `rx_s`.
- Counters:
  - Tick counter `s_cnt`, width `$clog2(OVERSAMPLE)`.
  - Bit counter `n_cnt`, width `$clog2(DATA_BITS)`.
  - Shift register `b_reg`, `DATA_BITS` wide.
- Counters advance only on cycles with `s_tick=1`.
- FSM states: IDLE, START, DATA, PARITY, STOP.
- IDLE:
  - On `rx_s==0`, go to START and clear `s_cnt`.
  - `s_tick` is not required to leave IDLE.
- START:
  - On the `s_tick` where `s_cnt==OVERSAMPLE/2-1` (mid start bit): if `rx_s==0`, go to DATA with `s_cnt=0`, `n_cnt=0`.
  - If `rx_s==1` at that point, treat it as a glitch: return to IDLE with no pulse.
- DATA:
  - On the `s_tick` where `s_cnt==OVERSAMPLE-1`: shift right, with `rx_s` entering the MSB (LSB-first line order), and clear `s_cnt`.
  - After `DATA_BITS` samples (`n_cnt==DATA_BITS-1`), go to PARITY if `PARITY_EN`, else STOP.
- PARITY: sample at `s_cnt==OVERSAMPLE-1`.
  - Even parity: error if `^b_reg ^ rx_s != 0`.
  - Odd parity: error if that value `!= 1`.
  - Then go to STOP.
- STOP: sample at `s_cnt==OVERSAMPLE-1`. In that cycle:
  - `dout <= b_reg`.
  - `frame_err <= ~rx_s`.
  - `parity_err <=` the computed result.
  - `rx_done_tick` = 1 for exactly one `clk`.
  - Go to IDLE.
- Stop-bit sampling:
  - Only one stop bit is sampled, at mid-bit. The receiver re-arms at mid-stop.
  - Frames with 2 stop bits are accepted.
- The done pulse is issued even when `frame_err`/`parity_err` is set. Error flags are held until the next done pulse.
- Frame-error IDLE entry: after a frame error, `rx_s` may still be low in IDLE. That immediately starts a new START (break condition); this is the required behaviour.
- `rx` changes between `s_tick`s are ignored except for the IDLE falling-edge detect.
- Reset values: FSM=IDLE, all counters 0, `b_reg`=0, `dout`=0, `rx_done_tick`=0, `frame_err`=0, `parity_err`=0.
- Reset mid-frame: discard the partial word and assert no pulse. The next frame must begin with a fresh falling edge.

## Timing
- Synchronizer latency: 2 `clk` from `rx` edge to `rx_s`.
- `rx_done_tick` is registered and asserts the `clk` after the mid-stop `s_tick`. `dout` and the error flags are valid in the same cycle and stable until the next pulse.
- Frame latency from `rx_s` falling edge to done: `OVERSAMPLE/2 + OVERSAMPLE*(DATA_BITS+PARITY_EN+1)` `s_tick`s. With defaults this is 152 ticks.
- No backpressure: the consumer must accept on `rx_done_tick`. Overrun is reported downstream, not here.
- Consecutive pulses are at least `OVERSAMPLE*(DATA_BITS+1)` ticks apart.

## Structure
- `uart_pkg` holds:
  - `rx_state_t` enum (IDLE/START/DATA/PARITY/STOP).
  - `UART_OVERSAMPLE` default constant, shared with the baud generator and transmitter.
- Sub-module `sync_2ff` (reset value parameter, here 1) instantiated for `rx`; reusable for other async inputs.
- FSM, counters and shift register stay in `uart_rx`.

## Test plan
- 8N1, tick every clk: send 0xA5 → one `rx_done_tick` 152 ticks after start edge, `dout=0xA5`, both errors 0.
- Glitch: `rx` low for 3 ticks, then high → no `rx_done_tick`, FSM back in IDLE, `dout` unchanged.
- Stop bit driven 0 after 0x3C → pulse with `dout=0x3C`, `frame_err=1`. Next good frame 0x55 clears `frame_err` to 0.
- `PARITY_EN=1`, even parity:
  - Send 0x07 with parity bit 1 → `parity_err=0`.
  - Send 0x07 with parity bit 0 → `parity_err=1`.
- Back-to-back frames 0x00, 0xFF, 0x81 with 1 stop bit → three pulses, values in order, no errors.
- Assert `rst_n=0` during data bit 4 → outputs return to reset values, no pulse. The following frame 0x12 is received correctly.
